// File: rtl/trap_unit_pkg.sv
// Shared types and constants for the machine-mode trap unit: FSM state encoding,
// interrupt cause codes, mip/mie bit positions and CSR addresses.
package trap_unit_pkg;

  typedef enum logic [0:0] {IDLE = 1'b0, FLUSH = 1'b1} trap_state_t;
  typedef enum logic [0:0] {DIRECT = 1'b0, VECTORED = 1'b1} mtvec_mode_t;

  localparam logic [4:0] CODE_MSI = 5'd3;
  localparam logic [4:0] CODE_MTI = 5'd7;
  localparam logic [4:0] CODE_MEI = 5'd11;

  localparam int unsigned BIT_MSI = 3;
  localparam int unsigned BIT_MTI = 7;
  localparam int unsigned BIT_MEI = 11;

  localparam logic [31:0] MIE_MASK    = 32'h0000_0888;
  localparam logic [31:0] MCAUSE_MASK = 32'h8000_001F;

  localparam logic [11:0] CSR_MIE    = 12'h304;
  localparam logic [11:0] CSR_MTVEC  = 12'h305;
  localparam logic [11:0] CSR_MEPC   = 12'h341;
  localparam logic [11:0] CSR_MCAUSE = 12'h342;
  localparam logic [11:0] CSR_MTVAL  = 12'h343;
  localparam logic [11:0] CSR_MIP    = 12'h344;

endpackage

// File: rtl/trap_csr_if.sv
// CSR access path between the CSR block (master) and the trap unit (slave).
interface trap_csr_if;
  logic        rd_en;
  logic        wr_en;
  logic [11:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output rd_en, wr_en, addr, wr_data, input rd_data);
  modport slave  (input rd_en, wr_en, addr, wr_data, output rd_data);
endinterface

// File: rtl/trap_unit_irq_sync.sv
// Multi-flop synchronizer bringing one asynchronous interrupt level into the clk domain.
module trap_unit_irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= '0;
    else        ff_q <= {ff_q[SYNC_STAGES-2:0], async_i};
  end

  assign sync_o = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/trap_unit.sv
// Machine-mode trap controller: owns mtvec/mie/mip/mepc/mcause/mtval, arbitrates
// exceptions against interrupts, raises trap and supplies the fetch redirect PC.
module trap_unit
  import trap_unit_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  trap_csr_if.slave        csr,
  input  logic             global_mie,
  input  logic             dbus_wait,
  input  logic [31:0]      inst_pc,
  input  logic             exc_valid,
  input  logic [4:0]       exc_cause,
  input  logic [31:0]      exc_tval,
  input  logic             mret,
  input  logic             meip_in,
  input  logic             mtip_in,
  input  logic             msip_in,
  output logic             trap,
  output logic [31:0]      trap_pc
);

  localparam logic [0:0] ST_IDLE  = IDLE;
  localparam logic [0:0] ST_FLUSH = FLUSH;
  localparam int unsigned CNT_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  logic [29:0]      mtvec_base_q;
  mtvec_mode_t      mtvec_mode_q;
  logic [31:0]      mie_q, mepc_q, mcause_q, mtval_q;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        meip_s, mtip_s, msip_s;
  logic [31:0] mip, pend, vec_base;
  logic [4:0]  irq_code, cause_code;
  logic        idle, irq_req, mret_take;

  trap_unit_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mei (.clk(clk), .rst_n(rst_n), .async_i(meip_in), .sync_o(meip_s));
  trap_unit_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_mti (.clk(clk), .rst_n(rst_n), .async_i(mtip_in), .sync_o(mtip_s));
  trap_unit_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_msi (.clk(clk), .rst_n(rst_n), .async_i(msip_in), .sync_o(msip_s));

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    mip          = '0;
    mip[BIT_MEI] = meip_s;
    mip[BIT_MTI] = mtip_s;
    mip[BIT_MSI] = msip_s;
  end

  assign pend      = mip & mie_q;
  assign idle      = (state_q == ST_IDLE);
  assign irq_req   = global_mie & (|pend) & ~dbus_wait & idle;
  assign trap      = idle & (exc_valid | irq_req);
  assign mret_take = mret & idle & ~trap;
  assign vec_base  = {mtvec_base_q, 2'b00};

  // Fixed interrupt priority: external, then software, then timer.
  always_comb begin
    if (pend[BIT_MEI])      irq_code = CODE_MEI;
    else if (pend[BIT_MSI]) irq_code = CODE_MSI;
    else                    irq_code = CODE_MTI;
  end

  assign cause_code = exc_valid ? exc_cause : irq_code;

  always_comb begin
    trap_pc = vec_base;
    if (trap) begin
      if (!exc_valid && mtvec_mode_q == VECTORED) trap_pc = vec_base + {25'd0, irq_code, 2'b00};
    end else if (mret) begin
      trap_pc = mepc_q;
    end
  end

  always_comb begin
    csr.rd_data = '0;
    if (csr.rd_en) begin
      case (csr.addr)
        CSR_MTVEC:  csr.rd_data = {mtvec_base_q, 1'b0, mtvec_mode_q};
        CSR_MIE:    csr.rd_data = mie_q;
        CSR_MIP:    csr.rd_data = mip;
        CSR_MEPC:   csr.rd_data = mepc_q;
        CSR_MCAUSE: csr.rd_data = mcause_q;
        CSR_MTVAL:  csr.rd_data = mtval_q;
        default:    csr.rd_data = '0;
      endcase
    end
  end

  // NOTE: CSR state is a handful of registers, not a memory, so every one is cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mtvec_base_q <= '0;
      mtvec_mode_q <= DIRECT;
      mie_q        <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else begin
      if (csr.wr_en) begin
        case (csr.addr)
          CSR_MTVEC: begin
            mtvec_base_q <= csr.wr_data[31:2];
            if (!csr.wr_data[1]) mtvec_mode_q <= mtvec_mode_t'(csr.wr_data[0]);
          end
          CSR_MIE:    mie_q    <= csr.wr_data & MIE_MASK;
          CSR_MEPC:   mepc_q   <= csr.wr_data & ~32'd3;
          CSR_MCAUSE: mcause_q <= csr.wr_data & MCAUSE_MASK;
          CSR_MTVAL:  mtval_q  <= csr.wr_data;
          default: ;
        endcase
      end
      // NOTE: non-blocking assignments let the later trap update override a same-cycle CSR write.
      if (trap) begin
        mepc_q   <= inst_pc & ~32'd3;
        mcause_q <= {~exc_valid, 26'd0, cause_code};
        mtval_q  <= exc_valid ? exc_tval : 32'd0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (trap || mret_take) begin
          state_d = ST_FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_trap_unit.sv
// Directed bench for trap_unit: CSR access, interrupt/exception arbitration, flush masking, mret, async reset.
module tb_trap_unit;
  import trap_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        global_mie = 1'b0, dbus_wait = 1'b0;
  logic [31:0] inst_pc = '0;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_cause = '0;
  logic [31:0] exc_tval = '0;
  logic        mret = 1'b0, meip_in = 1'b0, mtip_in = 1'b0, msip_in = 1'b0;
  logic        trap;
  logic [31:0] trap_pc;

  int n_asserts = 0;
  int n_fail    = 0;

  trap_csr_if csr_bus ();

  trap_unit #(.SYNC_STAGES(2), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .csr(csr_bus),
    .global_mie(global_mie), .dbus_wait(dbus_wait), .inst_pc(inst_pc),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
    .mret(mret), .meip_in(meip_in), .mtip_in(mtip_in), .msip_in(msip_in),
    .trap(trap), .trap_pc(trap_pc)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
    csr_bus.rd_en = 1'b1;
    csr_bus.addr  = a;
    #1;
    check(tag, csr_bus.rd_data, exp);
    csr_bus.rd_en = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    csr_bus.wr_en   = 1'b1;
    csr_bus.addr    = a;
    csr_bus.wr_data = d;
    step();
    csr_bus.wr_en   = 1'b0;
  endtask

  initial begin
    csr_bus.rd_en = 1'b0; csr_bus.wr_en = 1'b0; csr_bus.addr = '0; csr_bus.wr_data = '0;
    #3;
    check("reset_trap", {31'd0, trap}, 32'd0);
    csr_rd("reset_mtvec", CSR_MTVEC, 32'd0);
    csr_rd("reset_mip", CSR_MIP, 32'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Vectored timer interrupt through the two-flop synchronizer.
    csr_wr(CSR_MTVEC, 32'h1000_0001);
    csr_rd("mtvec_rb", CSR_MTVEC, 32'h1000_0001);
    csr_wr(CSR_MIE, 32'hFFFF_FFFF);
    csr_rd("mie_mask", CSR_MIE, 32'h0000_0888);
    csr_wr(CSR_MIE, 32'h0000_0880);
    inst_pc = 32'h0000_0300;
    global_mie = 1'b1;
    mtip_in = 1'b1;
    step();
    check("mti_sync_1cyc", {31'd0, trap}, 32'd0);
    step();
    check("mti_trap", {31'd0, trap}, 32'd1);
    check("mti_trap_pc", trap_pc, 32'h1000_001C);
    csr_rd("mti_mip", CSR_MIP, 32'h0000_0080);
    step();

    // Exception arrives during flush with MEI pending: masked, then wins over MEI.
    global_mie = 1'b0; mtip_in = 1'b0; meip_in = 1'b1;
    exc_valid = 1'b1; exc_cause = 5'd2; exc_tval = 32'hDEAD_BEEF; inst_pc = 32'h0000_0104;
    #1;
    check("flush_mask_0", {31'd0, trap}, 32'd0);
    csr_rd("mti_mcause", CSR_MCAUSE, 32'h8000_0007);
    csr_rd("mti_mepc", CSR_MEPC, 32'h0000_0300);
    csr_rd("mti_mtval", CSR_MTVAL, 32'd0);
    step();
    check("flush_mask_1", {31'd0, trap}, 32'd0);
    step();
    global_mie = 1'b1;
    mret = 1'b1;
    #1;
    check("exc_trap", {31'd0, trap}, 32'd1);
    check("exc_trap_pc", trap_pc, 32'h1000_0000);
    step();
    mret = 1'b0; exc_valid = 1'b0;
    csr_rd("exc_mepc", CSR_MEPC, 32'h0000_0104);
    csr_rd("exc_mtval", CSR_MTVAL, 32'hDEAD_BEEF);
    csr_rd("exc_mcause", CSR_MCAUSE, 32'h0000_0002);
    step();
    check("mei_flush", {31'd0, trap}, 32'd0);
    step();
    check("mei_trap", {31'd0, trap}, 32'd1);
    check("mei_trap_pc", trap_pc, 32'h1000_002C);
    step();
    csr_rd("mei_mcause", CSR_MCAUSE, 32'h8000_000B);
    csr_rd("mei_mtval", CSR_MTVAL, 32'd0);
    meip_in = 1'b0; global_mie = 1'b0;

    // dbus_wait holds off interrupts; MSI beats MTI; trap beats a same-cycle mepc write.
    csr_wr(CSR_MIE, 32'h0000_0888);
    dbus_wait = 1'b1; msip_in = 1'b1; mtip_in = 1'b1; global_mie = 1'b1; inst_pc = 32'h0000_0403;
    step(); step(); step();
    check("dbus_hold", {31'd0, trap}, 32'd0);
    csr_rd("dbus_mip", CSR_MIP, 32'h0000_0088);
    dbus_wait = 1'b0;
    csr_bus.wr_en = 1'b1; csr_bus.addr = CSR_MEPC; csr_bus.wr_data = 32'h0000_1234;
    #1;
    check("msi_trap", {31'd0, trap}, 32'd1);
    check("msi_trap_pc", trap_pc, 32'h1000_000C);
    step();
    csr_bus.wr_en = 1'b0;
    global_mie = 1'b0; msip_in = 1'b0; mtip_in = 1'b0;
    csr_rd("msi_mepc_wins", CSR_MEPC, 32'h0000_0400);
    csr_rd("msi_mcause", CSR_MCAUSE, 32'h8000_0003);
    step(); step(); step();

    // CSR write masking and unmapped address.
    csr_wr(CSR_MTVEC, 32'h2000_0003);
    csr_rd("mtvec_mode3", CSR_MTVEC, 32'h2000_0001);
    csr_wr(CSR_MTVEC, 32'h2000_0000);
    csr_rd("mtvec_mode0", CSR_MTVEC, 32'h2000_0000);
    csr_wr(CSR_MEPC, 32'h0000_0107);
    csr_rd("mepc_mask", CSR_MEPC, 32'h0000_0104);
    csr_wr(CSR_MCAUSE, 32'hFFFF_FFFF);
    csr_rd("mcause_mask", CSR_MCAUSE, 32'h8000_001F);
    csr_wr(CSR_MTVAL, 32'h1234_5678);
    csr_rd("mtval_rb", CSR_MTVAL, 32'h1234_5678);
    csr_wr(12'h300, 32'hFFFF_FFFF);
    csr_rd("unmapped", 12'h300, 32'd0);

    // mret redirect, flush entry, then asynchronous reset mid-flush.
    csr_wr(CSR_MEPC, 32'h0000_0200);
    mret = 1'b1;
    #1;
    check("mret_trap", {31'd0, trap}, 32'd0);
    check("mret_pc", trap_pc, 32'h0000_0200);
    step();
    mret = 1'b0;
    exc_valid = 1'b1; exc_cause = 5'd5;
    #1;
    check("mret_flush", {31'd0, trap}, 32'd0);
    exc_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_trap", {31'd0, trap}, 32'd0);
    csr_rd("rst_mepc", CSR_MEPC, 32'd0);
    csr_rd("rst_mtvec", CSR_MTVEC, 32'd0);
    csr_rd("rst_mcause", CSR_MCAUSE, 32'd0);
    csr_rd("rst_mtval", CSR_MTVAL, 32'd0);
    csr_rd("rst_mie", CSR_MIE, 32'd0);
    rst_n = 1'b1;
    exc_valid = 1'b1;
    #1;
    check("rst_idle_trap", {31'd0, trap}, 32'd1);
    check("rst_idle_pc", trap_pc, 32'd0);
    exc_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
